keypad_entry_sequencer: RTL and testbench

- Sits between the 10-key priority encoder and the 32-bit password comparator of the lock datapath.
- Debounces and edge-detects encoder output, then assembles NUM_DIGITS BCD digits into a packed code word.
- On ENTER with a full code, presents the word to the comparator with a one-cycle strobe.
- Also handles clear, short-entry error and inactivity timeout.

---
 rtl/lock_pkg.sv | 25 ++
 rtl/key_debounce.sv | 58 +++++
 rtl/keypad_entry_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_entry_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// ----------------------------------------------------------------------------
// lock_pkg
// Shared constants for the lock keypad datapath: entry-sequencer FSM state
// encoding, BCD key-code field positions and the packed code width helper.
// No ports.
// ----------------------------------------------------------------------------
package lock_pkg;

    // Entry sequencer state encoding
    localparam int unsigned         STATE_W   = 2;
    localparam logic [STATE_W-1:0]  ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0]  ST_ENTRY  = 2'd1;
    localparam logic [STATE_W-1:0]  ST_FULL   = 2'd2;
    localparam logic [STATE_W-1:0]  ST_SUBMIT = 2'd3;

    // Encoder output layout: {valid, bcd[3:0]}
    localparam int unsigned BCD_VALID_BIT = 4;
    localparam int unsigned DIGIT_W       = 4;

    // Width of a packed code word holding num_digits BCD digits
    function automatic int unsigned CODE_W(input int unsigned num_digits);
        return DIGIT_W * num_digits;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Level debouncer: the filtered output takes the raw value only once the raw
// value has been sampled unchanged on DEBOUNCE_CYCLES consecutive clock edges.
// Any change of any bit restarts the stability count.
// Ports:
//   clk   in   system clock, rising edge
//   rst_n in   asynchronous active-low reset (output and count clear to 0)
//   raw   in   [WIDTH] unfiltered input level
//   filt  out  [WIDTH] debounced level (registered)
// ----------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] filt
);

    localparam int unsigned         CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0]     CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // cnt_d = number of consecutive edges (including this one) at which raw has
    // held its current value, saturating at DEBOUNCE_CYCLES.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (raw != cand_q) begin
            cnt_d = CntW'(1);
        end else if (cnt_q < CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (cnt_d == CntMax) begin
            filt_d = raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
            filt_q <= '0;
        end else begin
            cand_q <= raw;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/keypad_entry_sequencer.sv
// ----------------------------------------------------------------------------
// keypad_entry_sequencer
// Debounces the keypad encoder and the ENTER/CLEAR buttons, assembles
// NUM_DIGITS BCD digits (first digit in the MSB nibble) and hands a complete
// code to the password comparator with a one-cycle strobe. Handles clear,
// short entry and inactivity timeout.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   key_code    in   [5] {key valid, BCD digit}
//   enter_in    in   raw ENTER level
//   clear_in    in   raw CLEAR level
//   code_out    out  [4*NUM_DIGITS] last submitted code, held until next submit
//   code_valid  out  one-cycle strobe, code_out valid in that cycle
//   digit_count out  [4] digits captured so far
//   short_err   out  one-cycle pulse: ENTER before the code was full
//   timeout     out  one-cycle pulse: partial entry discarded for inactivity
//   busy        out  an entry is in progress
// ----------------------------------------------------------------------------
module keypad_entry_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BCD_VALID_BIT:0]        key_code,
    input  logic                          enter_in,
    input  logic                          clear_in,
    output logic [CODE_W(NUM_DIGITS)-1:0] code_out,
    output logic                          code_valid,
    output logic [3:0]                    digit_count,
    output logic                          short_err,
    output logic                          timeout,
    output logic                          busy
);

    localparam int unsigned     CodeW     = CODE_W(NUM_DIGITS);
    localparam int unsigned     TmrW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmrW-1:0] TmrLast   = TmrW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      CountFull = 4'(NUM_DIGITS);

    // ---------------------------------------------------------------- debounce
    logic [BCD_VALID_BIT:0] key_filt;
    logic                   enter_filt;
    logic                   clear_filt;

    key_debounce #(
        .WIDTH           (BCD_VALID_BIT + 1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key_code),
        .filt  (key_filt)
    );

    key_debounce #(
        .WIDTH           (1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enter_in),
        .filt  (enter_filt)
    );

    key_debounce #(
        .WIDTH           (1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (clear_in),
        .filt  (clear_filt)
    );

    // ------------------------------------------------------------ edge detect
    logic key_prev_q, enter_prev_q, clear_prev_q;
    logic key_rise, enter_rise, clear_ev, enter_ev, key_ev;
    logic [DIGIT_W-1:0] digit;
    logic digit_ok;

    assign key_rise   = key_filt[BCD_VALID_BIT] & ~key_prev_q;
    assign enter_rise = enter_filt & ~enter_prev_q;
    assign clear_ev   = clear_filt & ~clear_prev_q;
    // Priority clear > enter > key; losers in the same cycle are dropped
    assign enter_ev   = enter_rise & ~clear_ev;
    assign key_ev     = key_rise & ~enter_rise & ~clear_ev;
    assign digit      = key_filt[DIGIT_W-1:0];
    assign digit_ok   = (digit <= DIGIT_W'(9));

    // --------------------------------------------------------------------- FSM
    logic [STATE_W-1:0] state_q, state_d;
    logic [CodeW-1:0]   shift_q, shift_d;
    logic [CodeW-1:0]   code_q, code_d;
    logic [3:0]         count_q, count_d;
    logic [TmrW-1:0]    tmr_q, tmr_d;
    logic               short_err_q, short_err_d;
    logic               timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        code_d      = code_q;
        count_d     = count_q;
        tmr_d       = tmr_q;
        short_err_d = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (key_ev && digit_ok) begin
                    shift_d = CodeW'(digit);
                    count_d = 4'd1;
                    state_d = (CountFull == 4'd1) ? ST_FULL : ST_ENTRY;
                end
            end

            ST_ENTRY, ST_FULL: begin
                if (clear_ev) begin
                    shift_d = '0;
                    count_d = '0;
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else if (enter_ev) begin
                    if (state_q == ST_FULL) begin
                        code_d  = shift_q;
                        state_d = ST_SUBMIT;
                    end else begin
                        short_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                    shift_d = '0;
                    count_d = '0;
                    tmr_d   = '0;
                end else if (key_ev && digit_ok && (state_q == ST_ENTRY)) begin
                    shift_d = (shift_q << DIGIT_W) | CodeW'(digit);
                    count_d = count_q + 4'd1;
                    tmr_d   = '0;
                    if (count_q + 4'd1 == CountFull) begin
                        state_d = ST_FULL;
                    end
                end else if (tmr_q == TmrLast) begin
                    // Ignored keys (FULL, non-BCD) do not count as activity
                    timeout_d = 1'b1;
                    shift_d   = '0;
                    count_d   = '0;
                    tmr_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end

            // One-cycle strobe; events arriving now are dropped
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            code_q       <= '0;
            count_q      <= '0;
            tmr_q        <= '0;
            short_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
            key_prev_q   <= 1'b0;
            enter_prev_q <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            code_q       <= code_d;
            count_q      <= count_d;
            tmr_q        <= tmr_d;
            short_err_q  <= short_err_d;
            timeout_q    <= timeout_d;
            key_prev_q   <= key_filt[BCD_VALID_BIT];
            enter_prev_q <= enter_filt;
            clear_prev_q <= clear_filt;
        end
    end

    // ----------------------------------------------------------------- outputs
    assign code_out    = code_q;
    assign code_valid  = (state_q == ST_SUBMIT);
    assign digit_count = count_q;
    assign short_err   = short_err_q;
    assign timeout     = timeout_q;
    assign busy        = (state_q == ST_ENTRY) || (state_q == ST_FULL);

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// ----------------------------------------------------------------------------
// tb_keypad_entry_sequencer
// Directed scenarios plus randomized key/button activity, checked every cycle
// against a behavioural model: debouncing as "last N samples identical", the
// code as a queue of digits packed arithmetically, and the timeout as a count
// of idle cycles.
// ----------------------------------------------------------------------------
module tb_keypad_entry_sequencer;

    localparam int ND = 8;
    localparam int DB = 4;
    localparam int TO = 150;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [4:0]  key_code = 5'd0;
    logic        enter_in = 1'b0;
    logic        clear_in = 1'b0;
    logic [31:0] code_out;
    logic        code_valid;
    logic [3:0]  digit_count;
    logic        short_err;
    logic        timeout;
    logic        busy;

    keypad_entry_sequencer #(
        .NUM_DIGITS      (ND),
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (key_code),
        .enter_in    (enter_in),
        .clear_in    (clear_in),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .digit_count (digit_count),
        .short_err   (short_err),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_digs[$];
    bit          m_submit;
    logic [31:0] m_code;
    bit          m_short;
    bit          m_tmo;
    int          m_idle;
    logic [4:0]  m_kf;
    logic        m_ef, m_cf;
    logic        m_kv_prev, m_ef_prev, m_cf_prev;
    logic [4:0]  h_key[$];
    logic        h_ent[$];
    logic        h_clr[$];

    // Observed pulse bookkeeping
    int          n_valid = 0;
    int          n_short = 0;
    int          n_tmo   = 0;
    logic [31:0] last_code = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_digs.delete();
        h_key.delete();
        h_ent.delete();
        h_clr.delete();
        m_submit  = 1'b0;
        m_code    = 32'd0;
        m_short   = 1'b0;
        m_tmo     = 1'b0;
        m_idle    = 0;
        m_kf      = 5'd0;
        m_ef      = 1'b0;
        m_cf      = 1'b0;
        m_kv_prev = 1'b0;
        m_ef_prev = 1'b0;
        m_cf_prev = 1'b0;
    endtask

    function automatic logic [31:0] pack_digits();
        logic [31:0] v = 32'd0;
        foreach (m_digs[i]) v = (v << 4) | 32'(m_digs[i]);
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic model_edge();
        bit ev_c, ev_e, ev_k, same;
        int d;
        ev_c = m_cf && !m_cf_prev;
        ev_e = m_ef && !m_ef_prev;
        ev_k = m_kf[4] && !m_kv_prev;
        d    = int'(m_kf[3:0]);
        if (ev_c) begin ev_e = 1'b0; ev_k = 1'b0; end
        if (ev_e) ev_k = 1'b0;
        m_short = 1'b0;
        m_tmo   = 1'b0;
        if (m_submit) begin
            m_submit = 1'b0;
        end else if (m_digs.size() == 0) begin
            if (ev_k && d <= 9) begin m_digs.push_back(d); m_idle = 0; end
        end else if (ev_c) begin
            m_digs.delete();
        end else if (ev_e) begin
            if (m_digs.size() < ND) m_short = 1'b1;
            else begin m_code = pack_digits(); m_submit = 1'b1; end
            m_digs.delete();
        end else if (ev_k && d <= 9 && m_digs.size() < ND) begin
            m_digs.push_back(d);
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle >= TO) begin m_tmo = 1'b1; m_digs.delete(); end
        end
        m_kv_prev = m_kf[4];
        m_ef_prev = m_ef;
        m_cf_prev = m_cf;
        h_key.push_back(key_code);
        h_ent.push_back(enter_in);
        h_clr.push_back(clear_in);
        if (h_key.size() > DB) void'(h_key.pop_front());
        if (h_ent.size() > DB) void'(h_ent.pop_front());
        if (h_clr.size() > DB) void'(h_clr.pop_front());
        if (h_key.size() == DB) begin
            same = 1'b1;
            foreach (h_key[i]) if (h_key[i] != key_code) same = 1'b0;
            if (same) m_kf = key_code;
            same = 1'b1;
            foreach (h_ent[i]) if (h_ent[i] != enter_in) same = 1'b0;
            if (same) m_ef = enter_in;
            same = 1'b1;
            foreach (h_clr[i]) if (h_clr[i] != clear_in) same = 1'b0;
            if (same) m_cf = clear_in;
        end
    endtask

    task automatic compare_all();
        check_eq("code_out", code_out, m_code);
        check_eq("code_valid", 32'(code_valid), 32'(m_submit));
        check_eq("digit_count", 32'(digit_count), 32'(m_digs.size()));
        check_eq("short_err", 32'(short_err), 32'(m_short));
        check_eq("timeout", 32'(timeout), 32'(m_tmo));
        check_eq("busy", 32'(busy), 32'(m_digs.size() > 0));
    endtask

    task automatic step(input logic [4:0] k, input logic e, input logic c);
        key_code = k;
        enter_in = e;
        clear_in = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (code_valid) begin n_valid++; last_code = code_out; end
        if (short_err) n_short++;
        if (timeout) n_tmo++;
    endtask

    task automatic press_key(input logic [3:0] d, input int hold, input int gap);
        repeat (hold) step({1'b1, d}, 1'b0, 1'b0);
        repeat (gap) step(5'd0, 1'b0, 1'b0);
    endtask

    task automatic press_btn(input logic e, input logic c, input int hold, input int gap);
        repeat (hold) step(5'd0, e, c);
        repeat (gap) step(5'd0, 1'b0, 1'b0);
    endtask

    task automatic enter_digits(input logic [31:0] code, input int n);
        for (int i = n - 1; i >= 0; i--) press_key(4'(code >> (4 * i)), 10, 10);
    endtask

    task automatic run_random(input int iters);
        int r, hold, gap;
        for (int it = 0; it < iters; it++) begin
            r    = int'($urandom_range(0, 99));
            hold = int'($urandom_range(1, 12));
            gap  = int'($urandom_range(1, 12));
            if (r < 60) begin
                press_key(4'($urandom_range(0, 11)), hold, gap);
            end else if (r < 70) begin
                repeat (hold) step(5'($urandom_range(0, 31)), 1'b0, 1'b0);
            end else if (r < 82) begin
                press_btn(1'b1, 1'b0, hold, gap);
            end else if (r < 87) begin
                press_btn(1'b0, 1'b1, hold, gap);
            end else if (r < 93) begin
                repeat (int'($urandom_range(100, 200))) step(5'd0, 1'b0, 1'b0);
            end else begin
                repeat (hold) step(5'($urandom_range(0, 31)),
                                   1'($urandom_range(0, 3) == 0),
                                   1'($urandom_range(0, 3) == 0));
            end
        end
    endtask

    int v0, s0, t0;

    initial begin
        model_reset();
        #22;
        compare_all();
        rst_n = 1'b1;

        // Full code submit
        v0 = n_valid;
        enter_digits(32'h12345678, 8);
        check_eq("t1_full_count", 32'(digit_count), 32'd8);
        press_btn(1'b1, 1'b0, 10, 10);
        check_eq("t1_valid_pulses", 32'(n_valid - v0), 32'd1);
        check_eq("t1_code", last_code, 32'h12345678);
        check_eq("t1_count_zero", 32'(digit_count), 32'd0);

        // Glitches shorter than the debounce window are not keys
        repeat (2) begin
            repeat (2) step(5'h15, 1'b0, 1'b0);
            repeat (2) step(5'h00, 1'b0, 1'b0);
        end
        check_eq("t2_no_glitch_key", 32'(digit_count), 32'd0);
        repeat (10) step(5'h15, 1'b0, 1'b0);
        check_eq("t2_one_digit", 32'(digit_count), 32'd1);
        repeat (10) step(5'h00, 1'b0, 1'b0);
        press_btn(1'b0, 1'b1, 10, 10);
        check_eq("t2_cleared", 32'(digit_count), 32'd0);

        // Short entry
        s0 = n_short;
        enter_digits(32'h00000321, 3);
        press_btn(1'b1, 1'b0, 10, 10);
        check_eq("t3_short_pulses", 32'(n_short - s0), 32'd1);
        check_eq("t3_busy", 32'(busy), 32'd0);
        check_eq("t3_code_held", code_out, 32'h12345678);

        // Ninth digit on a full entry is ignored
        enter_digits(32'h87654321, 8);
        press_key(4'd9, 10, 10);
        check_eq("t4_count_sat", 32'(digit_count), 32'd8);
        press_btn(1'b1, 1'b0, 10, 10);
        check_eq("t4_code", last_code, 32'h87654321);

        // Inactivity timeout, then simultaneous clear+enter on a full entry
        t0 = n_tmo;
        enter_digits(32'h00002468, 4);
        repeat (TO + 20) step(5'd0, 1'b0, 1'b0);
        check_eq("t5_timeout_pulses", 32'(n_tmo - t0), 32'd1);
        check_eq("t5_count_zero", 32'(digit_count), 32'd0);
        v0 = n_valid;
        enter_digits(32'h11223344, 8);
        press_btn(1'b1, 1'b1, 10, 10);
        check_eq("t5_clear_wins_count", 32'(digit_count), 32'd0);
        check_eq("t5_no_valid", 32'(n_valid - v0), 32'd0);

        // Asynchronous reset mid-entry
        enter_digits(32'h00000975, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_code", code_out, 32'd0);
        check_eq("t6_rst_count", 32'(digit_count), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        model_reset();
        compare_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        press_key(4'd4, 10, 10);
        check_eq("t6_fresh_count", 32'(digit_count), 32'd1);
        enter_digits(32'h00000001, 7);
        press_btn(1'b1, 1'b0, 10, 10);
        check_eq("t6_fresh_code", last_code, 32'h40000001);

        run_random(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
